uart_rx_sampler: RTL

- UART receive front end: 2-FF input synchronizer, 16x oversampling baud tick generator, start-bit qualification, mid-bit sampling, LSB-first deserialization.
- Sits directly upstream of the frame analysis/loopback logic in Top.
- Consumes the raw `rx` pin; delivers one byte per frame with a single-cycle valid pulse plus error flags.

---
 rtl/uart_rx_sampler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
// UART receive front end: 2-FF synchronizer, 16x oversampling tick, start-bit
// qualification, mid-bit sampling, LSB-first deserialization. Optional parity: UART_RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int CLK_DIV   = 163,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam logic [15:0] TICK_MAX   = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic [3:0]  MID_START  = 4'd7;
    localparam logic [3:0]  LAST_SAMPL = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   sync_meta_q;
    logic                   rx_s_q;
    logic [15:0]            tick_cnt_q;
    logic [15:0]            tick_cnt_d;
    logic                   tick_s;
    logic [3:0]             sample_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_done_q;
    logic                   frame_err_q;
    logic                   busy_q;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit_q;
    logic                   parity_err_q;

    // Even parity over data plus received parity bit: total number of ones must be even.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                            input logic                 par);
        return ~((^data) ^ par);
    endfunction
`endif

    // Two-stage synchronizer for the asynchronous rx pin; idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            sync_meta_q <= rx;
            rx_s_q      <= sync_meta_q;
        end
    end

    // Oversample tick: free-running, never realigned to the start edge.
    always_comb begin
        tick_s     = 1'b0;
        tick_cnt_d = tick_cnt_q;
        if (tick_cnt_q == TICK_MAX) begin
            tick_s     = 1'b1;
            tick_cnt_d = 16'd0;
        end else begin
            tick_s     = 1'b0;
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    // Tick counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= 16'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Receive FSM with registered data, pulse and busy outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= 4'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q      <= ST_START;
                        sample_cnt_q <= 4'd0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (sample_cnt_q == MID_START) begin
                            // A start bit still low at its centre is genuine; anything else was a glitch.
                            if (!rx_s_q) begin
                                state_q      <= ST_DATA;
                                sample_cnt_q <= 4'd0;
                                bit_cnt_q    <= 4'd0;
                            end else begin
                                state_q      <= ST_IDLE;
                                sample_cnt_q <= 4'd0;
                                busy_q       <= 1'b0;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (sample_cnt_q == LAST_SAMPL) begin
                            shift_q      <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            sample_cnt_q <= 4'd0;
                            bit_cnt_q    <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        if (sample_cnt_q == LAST_SAMPL) begin
                            parity_bit_q <= rx_s_q;
                            sample_cnt_q <= 4'd0;
                            state_q      <= ST_STOP;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        if (sample_cnt_q == LAST_SAMPL) begin
                            state_q      <= ST_IDLE;
                            sample_cnt_q <= 4'd0;
                            busy_q       <= 1'b0;
                            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                                if (even_parity_ok(shift_q, parity_bit_q)) begin
                                    rx_data_q <= shift_q;
                                    rx_done_q <= 1'b1;
                                end else begin
                                    parity_err_q <= 1'b1;
                                end
`else
                                rx_data_q <= shift_q;
                                rx_done_q <= 1'b1;
`endif
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    sample_cnt_q <= 4'd0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
